// File: rtl/ahb_slave_if_if.sv
// Bus bundle for the AHB-Lite slave front end: the AHB master-facing signals plus
// the request/response channel toward the APB controller.
interface ahb_slave_if_if;
  // AHB-Lite side
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  // Request FIFO head toward the APB controller
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_sel;

  // Read data returning from the APB controller
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata,
    input  req_ready, rsp_valid, rsp_rdata,
    output hreadyout, hresp, hrdata,
    output req_valid, req_write, req_addr, req_wdata, req_sel
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata,
    output req_ready, rsp_valid, rsp_rdata,
    input  hreadyout, hresp, hrdata,
    input  req_valid, req_write, req_addr, req_wdata, req_sel
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: decodes the peripheral select,
// queues accepted transfers in an in-order request FIFO and drives the AHB response.
module ahb_slave_if #(
  parameter int DEPTH = 4
) (
  input  logic          hclk,
  input  logic          hresetn,
  ahb_slave_if_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sel;
  } req_t;

  state_e         r_state;
  state_e         w_state_nxt;
  state_e         w_dispatch;

  logic [31:0]    r_addr;
  logic           r_write;
  logic [2:0]     r_sel;
  logic           r_rd_pushed;
  logic [31:0]    r_hrdata;

  req_t           r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  req_t           w_push_data;
  req_t           w_head;

  logic [2:0]     w_sel_dec;
  logic           w_can_accept;
  logic           w_accept;
  logic           w_ready;
  logic [1:0]     w_hresp;
  logic           w_load_rd;

  // ------------------------------------------------------------------
  // Address decode: one select line per 64 MiB peripheral window
  // ------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_sel_dec = 3'b000;
    unique case (bus.haddr[31:26])
      6'h20:   w_sel_dec = 3'b001;
      6'h21:   w_sel_dec = 3'b010;
      6'h22:   w_sel_dec = 3'b100;
      default: w_sel_dec = 3'b000;
    endcase
  end

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // ------------------------------------------------------------------
  // Response outputs come only from registered state and FIFO count
  // ------------------------------------------------------------------
  always_comb begin
    w_ready      = 1'b1;
    w_hresp      = HRESP_OKAY;
    w_can_accept = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_can_accept = 1'b1;
      ST_WRITE: begin
        w_ready      = !w_full;
        w_can_accept = !w_full;
      end
      ST_READ:  w_ready = 1'b0;
      ST_RDONE: w_can_accept = 1'b1;
      ST_ERR1: begin
        w_ready = 1'b0;
        w_hresp = HRESP_ERROR;
      end
      ST_ERR2:  w_hresp = HRESP_ERROR;
      default: begin
        w_ready      = 1'b1;
        w_hresp      = HRESP_OKAY;
        w_can_accept = 1'b0;
      end
    endcase
  end

  // ERR2 shows hreadyout=1 but is a completion cycle, so it never accepts.
  assign w_accept = w_can_accept & bus.hreadyin & bus.htrans[1];

  always_comb begin
    w_dispatch = ST_IDLE;
    if (w_accept) begin
      if (w_sel_dec == 3'b000) begin
        w_dispatch = ST_ERR1;
      end else if (bus.hwrite) begin
        w_dispatch = ST_WRITE;
      end else begin
        w_dispatch = ST_READ;
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM next state, FIFO push and read-completion load
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    w_load_rd   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_RDONE: w_state_nxt = w_dispatch;
      ST_WRITE: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = '{write: 1'b1, addr: r_addr, wdata: bus.hwdata, sel: r_sel};
          w_state_nxt = w_dispatch;
        end
      end
      ST_READ: begin
        if (!r_rd_pushed) begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_push_data = '{write: 1'b0, addr: r_addr, wdata: 32'h0, sel: r_sel};
          end
        end else if (w_empty && bus.rsp_valid) begin
          // Nothing else is pushed while reading, so an empty FIFO means the read entry was popped.
          w_load_rd   = 1'b1;
          w_state_nxt = ST_RDONE;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state     <= ST_IDLE;
      r_rd_pushed <= 1'b0;
      r_hrdata    <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_READ && w_push) begin
        r_rd_pushed <= 1'b1;
      end else if (w_state_nxt != ST_READ) begin
        r_rd_pushed <= 1'b0;
      end
      if (w_load_rd) begin
        r_hrdata <= bus.rsp_rdata;
      end
    end
  end

  // Address-phase capture
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_addr  <= 32'h0;
      r_write <= 1'b0;
      r_sel   <= 3'b000;
    end else if (w_accept) begin
      r_addr  <= bus.haddr;
      r_write <= bus.hwrite;
      r_sel   <= w_sel_dec;
    end
  end

  // ------------------------------------------------------------------
  // Request FIFO: full is judged before any same-cycle pop
  // ------------------------------------------------------------------
  assign w_pop = !w_empty && bus.req_ready;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage array has no reset; the head is masked to zero while empty, so stale contents never leak.
  always_ff @(posedge hclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rptr];

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.hreadyout = w_ready;
  assign bus.hresp     = w_hresp;
  assign bus.hrdata    = r_hrdata;
  assign bus.req_valid = !w_empty;
  assign bus.req_write = w_head.write;
  assign bus.req_addr  = w_head.addr;
  assign bus.req_wdata = w_head.wdata;
  assign bus.req_sel   = w_head.sel;

  // Captured direction is kept for debug visibility; the state already encodes it.
  logic w_unused;
  assign w_unused = r_write;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if: a table of single transfers plus
// hand-written sequences for burst back-pressure, read latency, ordering and reset.
module tb_ahb_slave_if;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  logic hclk;
  logic hresetn;

  ahb_slave_if_if bus ();

  ahb_slave_if #(.DEPTH(4)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } pop_t;

  pop_t popq[$];

  // Record every entry the APB side takes (pop occurs at the following rising edge)
  always @(negedge hclk) begin
    if (hresetn && bus.req_valid && bus.req_ready) begin
      popq.push_back('{bus.req_write, bus.req_addr, bus.req_wdata, bus.req_sel});
    end
  end

  typedef struct {
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        exp_push;
    logic [2:0]  exp_sel;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic [1:0] tr, input logic wr, input logic [31:0] addr);
    bus.htrans = tr;
    bus.hwrite = wr;
    bus.haddr  = addr;
  endtask

  // Wait (bounded) for hreadyout, then pass the edge that completes the data phase
  task automatic complete_beat(input string name);
    int n;
    n = 0;
    while (bus.hreadyout !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check({name, " ready"}, 32'(bus.hreadyout), 32'd1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   n;

    vecs[0] = '{HT_NONSEQ, 1'b1, 32'h8000_0038, 32'h0000_0080, 1'b1, 3'b001, 1'b0};
    vecs[1] = '{HT_NONSEQ, 1'b1, 32'h8800_0004, 32'h1234_5678, 1'b1, 3'b100, 1'b0};
    vecs[2] = '{HT_SEQ,    1'b1, 32'h87FF_FFFC, 32'hA5A5_0001, 1'b1, 3'b010, 1'b0};
    vecs[3] = '{HT_IDLE,   1'b1, 32'h8000_0000, 32'h1111_1111, 1'b0, 3'b000, 1'b0};
    vecs[4] = '{HT_BUSY,   1'b1, 32'h8000_0000, 32'h2222_2222, 1'b0, 3'b000, 1'b0};
    vecs[5] = '{HT_NONSEQ, 1'b1, 32'h8C00_0000, 32'h3333_3333, 1'b0, 3'b000, 1'b1};
    vecs[6] = '{HT_NONSEQ, 1'b1, 32'h7FFF_FFFC, 32'h4444_4444, 1'b0, 3'b000, 1'b1};
    vecs[7] = '{HT_NONSEQ, 1'b0, 32'h0000_0038, 32'h0000_0000, 1'b0, 3'b000, 1'b1};
    vecs[8] = '{HT_NONSEQ, 1'b1, 32'h83FF_FFFC, 32'hFFFF_FFFF, 1'b1, 3'b001, 1'b0};

    hresetn       = 1'b0;
    bus.htrans    = HT_IDLE;
    bus.hwrite    = 1'b0;
    bus.hreadyin  = 1'b1;
    bus.haddr     = 32'h0;
    bus.hwdata    = 32'h0;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge hclk);
    #1;
    check("rst hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rst hresp",     32'(bus.hresp),     32'd0);
    check("rst hrdata",    bus.hrdata,         32'h0);
    check("rst req_valid", 32'(bus.req_valid), 32'd0);
    check("rst req_addr",  bus.req_addr,       32'h0);
    check("rst req_sel",   32'(bus.req_sel),   32'd0);
    hresetn = 1'b1;
    cyc();

    // ---------------- table: single transfers from idle ----------------
    foreach (vecs[i]) begin
      popq.delete();
      drive_addr(vecs[i].htrans, vecs[i].hwrite, vecs[i].haddr);
      cyc();
      bus.htrans = HT_IDLE;
      bus.hwdata = vecs[i].hwdata;
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d err1 hready", i), 32'(bus.hreadyout), 32'd0);
        check($sformatf("v%0d err1 hresp", i),  32'(bus.hresp),     32'd1);
        cyc();
        check($sformatf("v%0d err2 hready", i), 32'(bus.hreadyout), 32'd1);
        check($sformatf("v%0d err2 hresp", i),  32'(bus.hresp),     32'd1);
        check($sformatf("v%0d err2 no push", i), 32'(bus.req_valid), 32'd0);
        cyc();
        check($sformatf("v%0d after hresp", i), 32'(bus.hresp),     32'd0);
        check($sformatf("v%0d after hready", i), 32'(bus.hreadyout), 32'd1);
        check($sformatf("v%0d after no push", i), 32'(bus.req_valid), 32'd0);
      end else begin
        check($sformatf("v%0d dphase hready", i), 32'(bus.hreadyout), 32'd1);
        check($sformatf("v%0d dphase hresp", i),  32'(bus.hresp),     32'd0);
        cyc();
        check($sformatf("v%0d req_valid", i), 32'(bus.req_valid), 32'(vecs[i].exp_push));
        if (vecs[i].exp_push) begin
          check($sformatf("v%0d req_write", i), 32'(bus.req_write), 32'd1);
          check($sformatf("v%0d req_addr", i),  bus.req_addr,       vecs[i].haddr);
          check($sformatf("v%0d req_wdata", i), bus.req_wdata,      vecs[i].hwdata);
          check($sformatf("v%0d req_sel", i),   32'(bus.req_sel),   32'(vecs[i].exp_sel));
        end
        cyc();
        check($sformatf("v%0d req_valid drop", i), 32'(bus.req_valid), 32'd0);
      end
      check($sformatf("v%0d pops", i), 32'(popq.size()), 32'(vecs[i].exp_push));
    end

    // ---------------- 8-beat INCR write burst with back-pressure ----------------
    popq.delete();
    bus.req_ready = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      bus.htrans = (i == 8) ? HT_IDLE : ((i == 0) ? HT_NONSEQ : HT_SEQ);
      bus.hwrite = 1'b1;
      bus.haddr  = 32'h8000_0100 + 32'(4 * i);
      bus.hwdata = (i > 0) ? (32'h0000_00A0 + 32'(i - 1)) : 32'h0;
      if (i >= 1 && i <= 4) begin
        check($sformatf("burst beat%0d zero wait", i), 32'(bus.hreadyout), 32'd1);
      end
      if (i == 5) begin
        check("burst beat5 stall", 32'(bus.hreadyout), 32'd0);
        bus.req_ready = 1'b1;
      end
      complete_beat($sformatf("burst beat%0d", i));
    end
    n = 0;
    while (popq.size() < 8 && n < 30) begin
      cyc();
      n++;
    end
    check("burst pop count", 32'(popq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < popq.size()) begin
        check($sformatf("burst pop%0d addr", k),  popq[k].a, 32'h8000_0100 + 32'(4 * k));
        check($sformatf("burst pop%0d wdata", k), popq[k].d, 32'h0000_00A0 + 32'(k));
      end
    end

    // ---------------- single read, 3 wait states ----------------
    popq.delete();
    drive_addr(HT_NONSEQ, 1'b0, 32'h8400_0010);
    cyc();
    bus.htrans = HT_IDLE;
    check("rd wait1", 32'(bus.hreadyout), 32'd0);
    cyc();
    check("rd wait2",      32'(bus.hreadyout), 32'd0);
    check("rd req_valid",  32'(bus.req_valid), 32'd1);
    check("rd req_write",  32'(bus.req_write), 32'd0);
    check("rd req_addr",   bus.req_addr,       32'h8400_0010);
    check("rd req_wdata",  bus.req_wdata,      32'h0);
    check("rd req_sel",    32'(bus.req_sel),   32'd2);
    cyc();
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'hDEAD_BEEF;
    check("rd wait3", 32'(bus.hreadyout), 32'd0);
    cyc();
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
    check("rd done hready", 32'(bus.hreadyout), 32'd1);
    check("rd done hresp",  32'(bus.hresp),     32'd0);
    check("rd done hrdata", bus.hrdata,         32'hDEAD_BEEF);
    cyc();
    check("rd hrdata held", bus.hrdata, 32'hDEAD_BEEF);

    // ---------------- two writes then a read, early rsp_valid ignored ----------------
    popq.delete();
    drive_addr(HT_NONSEQ, 1'b1, 32'h8000_0200);
    cyc();
    bus.hwdata = 32'h11;
    drive_addr(HT_NONSEQ, 1'b1, 32'h8000_0204);
    check("wwr w1 ready", 32'(bus.hreadyout), 32'd1);
    cyc();
    bus.hwdata = 32'h22;
    drive_addr(HT_NONSEQ, 1'b0, 32'h8800_0008);
    check("wwr w2 ready", 32'(bus.hreadyout), 32'd1);
    cyc();
    bus.htrans    = HT_IDLE;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'hBAD0_BAD0;
    check("wwr rd wait a", 32'(bus.hreadyout), 32'd0);
    cyc();
    check("wwr rd wait b", 32'(bus.hreadyout), 32'd0);
    cyc();
    bus.rsp_valid = 1'b0;
    check("wwr early rsp ignored", 32'(bus.hreadyout), 32'd0);
    check("wwr hrdata unchanged",  bus.hrdata,         32'hDEAD_BEEF);
    cyc();
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'h0000_CAFE;
    check("wwr rd wait d", 32'(bus.hreadyout), 32'd0);
    cyc();
    bus.rsp_valid = 1'b0;
    check("wwr rd done",   32'(bus.hreadyout), 32'd1);
    check("wwr rd hrdata", bus.hrdata,         32'h0000_CAFE);
    check("wwr pop count", 32'(popq.size()),   32'd3);
    if (popq.size() == 3) begin
      check("wwr pop0 addr",  popq[0].a,       32'h8000_0200);
      check("wwr pop0 write", 32'(popq[0].w),  32'd1);
      check("wwr pop0 wdata", popq[0].d,       32'h11);
      check("wwr pop1 addr",  popq[1].a,       32'h8000_0204);
      check("wwr pop1 wdata", popq[1].d,       32'h22);
      check("wwr pop2 addr",  popq[2].a,       32'h8800_0008);
      check("wwr pop2 write", 32'(popq[2].w),  32'd0);
      check("wwr pop2 sel",   32'(popq[2].s),  32'd4);
    end
    cyc();

    // ---------------- reset during a read with 2 entries buffered ----------------
    popq.delete();
    bus.req_ready = 1'b0;
    drive_addr(HT_NONSEQ, 1'b1, 32'h8000_0300);
    cyc();
    bus.hwdata = 32'h1;
    drive_addr(HT_NONSEQ, 1'b1, 32'h8000_0304);
    cyc();
    bus.hwdata = 32'h2;
    drive_addr(HT_NONSEQ, 1'b0, 32'h8000_0308);
    cyc();
    bus.htrans = HT_IDLE;
    check("rstrd buffered", 32'(bus.req_valid), 32'd1);
    check("rstrd in read",  32'(bus.hreadyout), 32'd0);
    hresetn = 1'b0;
    #1;
    check("rstrd req_valid", 32'(bus.req_valid), 32'd0);
    check("rstrd hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rstrd hresp",     32'(bus.hresp),     32'd0);
    #2;
    hresetn       = 1'b1;
    bus.req_ready = 1'b1;
    cyc();
    cyc();
    check("rstrd idle no push", 32'(bus.req_valid), 32'd0);
    check("rstrd idle ready",   32'(bus.hreadyout), 32'd1);
    check("rstrd no pops",      32'(popq.size()),   32'd0);

    // A fresh write after reset goes straight through
    drive_addr(HT_NONSEQ, 1'b1, 32'h8800_0010);
    cyc();
    bus.htrans = HT_IDLE;
    bus.hwdata = 32'h55;
    check("post rst zero wait", 32'(bus.hreadyout), 32'd1);
    cyc();
    check("post rst req_valid", 32'(bus.req_valid), 32'd1);
    check("post rst req_addr",  bus.req_addr,       32'h8800_0010);
    check("post rst req_wdata", bus.req_wdata,      32'h55);
    check("post rst req_sel",   32'(bus.req_sel),   32'd4);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
